// File: rtl/popcount_pipe_if.sv
// popcount_pipe_if: handshake bundle for popcount_pipe.
// The master side drives the operand and consumes the result.
// The slave side is the popcount pipeline itself.
interface popcount_pipe_if #(
    parameter int DATA_W = 64,
    parameter int ACC_W  = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [1:0]        in_mode;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_count;
    logic              out_sat;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_count, out_sat
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_count, out_sat
    );
endinterface

// File: rtl/popcount_pipe.sv
// popcount_pipe: three-stage population-count pipeline with valid/ready flow control.
//   S1 registers the operand and mode.
//   S2 registers one popcount per CHUNK_W-bit chunk.
//   S3 sums the chunks, applies the mode and registers the result.
// The whole pipeline freezes while a result is waiting on the consumer.
// Optional macro POPCOUNT_PIPE_ACC_EN adds the saturating accumulator (modes 10/11).
// Without it, modes 10/11 count ones like mode 00 and out_sat is tied low.
module popcount_pipe #(
    parameter int DATA_W  = 64,
    parameter int CHUNK_W = 8,
    parameter int ACC_W   = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    popcount_pipe_if.slave bus
);
    localparam int N     = DATA_W / CHUNK_W;
    localparam int CNT_W = $clog2(CHUNK_W + 1);
    localparam int SUM_W = $clog2(DATA_W + 1);

    // Ones in one chunk.
    function automatic logic [CNT_W-1:0] chunk_ones(input logic [CHUNK_W-1:0] c);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < CHUNK_W; i++) begin
            n = n + CNT_W'(c[i]);
        end
        return n;
    endfunction

`ifdef POPCOUNT_PIPE_ACC_EN
    // Saturating add; the top bit of the result flags that clamping happened.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [SUM_W-1:0] b);
        logic [ACC_W:0] s;
        s = {1'b0, a} + (ACC_W + 1)'(b);
        if (s[ACC_W]) begin
            return {1'b1, {ACC_W{1'b1}}};
        end
        return s;
    endfunction
`endif

    logic              stall;

    logic              vld_p0;
    logic [DATA_W-1:0] data_p0;
    logic [1:0]        mode_p0;

    logic              vld_p1;
    logic [CNT_W-1:0]  cnt_p1 [N];
    logic [1:0]        mode_p1;

    logic              vld_p2;
    logic [ACC_W-1:0]  count_p2;

    logic [SUM_W-1:0]  ones_sum;
    logic [SUM_W-1:0]  zeros;
    logic [ACC_W-1:0]  result_next;

    // A held result blocks every stage; ready is independent of in_valid.
    assign stall        = vld_p2 & ~bus.out_ready;
    assign bus.in_ready = ~stall;

    // ---- S1: operand capture ----
    // S1 valid: bubbles enter whenever the pipe advances without a new word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
        end else if (!stall) begin
            vld_p0 <= bus.in_valid;
        end
    end

    // S1 data: no reset needed, qualified by vld_p0.
    always_ff @(posedge clk) begin
        if (!stall) begin
            data_p0 <= bus.in_data;
            mode_p0 <= bus.in_mode;
        end
    end

    // ---- S2: per-chunk popcounts ----
    // S2 valid follows S1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (!stall) begin
            vld_p1 <= vld_p0;
        end
    end

    // S2 data: one small popcount per chunk keeps the S3 adder tree short.
    always_ff @(posedge clk) begin
        if (!stall) begin
            for (int i = 0; i < N; i++) begin
                cnt_p1[i] <= chunk_ones(data_p0[i*CHUNK_W +: CHUNK_W]);
            end
            mode_p1 <= mode_p0;
        end
    end

    // ---- S3: chunk sum, mode select, result register ----
    // Sum the chunk counts into the full-word popcount.
    always_comb begin
        ones_sum = '0;
        for (int i = 0; i < N; i++) begin
            ones_sum = ones_sum + SUM_W'(cnt_p1[i]);
        end
    end

    assign zeros = SUM_W'(DATA_W) - ones_sum;

`ifdef POPCOUNT_PIPE_ACC_EN
    logic [ACC_W-1:0] acc_p2;
    logic             sat_p2;
    logic [ACC_W:0]   acc_sum;

    assign acc_sum = sat_add(acc_p2, ones_sum);

    // Accumulator and sticky saturation change only on a valid S3 load, so order follows input order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_p2 <= '0;
            sat_p2 <= 1'b0;
        end else if (!stall && vld_p1) begin
            if (mode_p1 == 2'b10) begin
                acc_p2 <= acc_sum[ACC_W-1:0];
                if (acc_sum[ACC_W]) begin
                    sat_p2 <= 1'b1;
                end
            end else if (mode_p1 == 2'b11) begin
                acc_p2 <= ACC_W'(ones_sum);
                sat_p2 <= 1'b0;
            end
        end
    end

    assign bus.out_sat = sat_p2;
`else
    assign bus.out_sat = 1'b0;
`endif

    // Result selection; modes 00 and 11 report ones (also 10 without the accumulator).
    always_comb begin
        result_next = ACC_W'(ones_sum);
        case (mode_p1)
            2'b01:   result_next = ACC_W'(zeros);
`ifdef POPCOUNT_PIPE_ACC_EN
            2'b10:   result_next = acc_sum[ACC_W-1:0];
`endif
            default: result_next = ACC_W'(ones_sum);
        endcase
    end

    // S3 register: output valid and count, both frozen during a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2   <= 1'b0;
            count_p2 <= '0;
        end else if (!stall) begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                count_p2 <= result_next;
            end
        end
    end

    assign bus.out_valid = vld_p2;
    assign bus.out_count = count_p2;
endmodule
